// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter.
package bram_arb_pkg;

  // Arbiter operating mode: normal arbitration or array clear.
  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Widest requester vector any instance may use.
  localparam int unsigned MAX_REQ = 8;

  // One-hot vector with bit 'index' set; callers narrow it to their width.
  function automatic logic [MAX_REQ-1:0] onehot_of(input int unsigned index);
    onehot_of = MAX_REQ'(1) << index;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker for requesters 1..NUM_REQ-1. Purely combinational.
// The search starts at ptr and wraps from NUM_REQ-1 back to 1.
module rr_picker #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:1] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  int unsigned cand;

  // First eligible requester in rotation order starting at ptr.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
      cand = ((32'(ptr) - 1 + k) % (NUM_REQ - 1)) + 1;
      if (!valid && eligible[cand]) begin
        valid  = 1'b1;
        winner = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one synchronous, write-first BRAM port between NUM_REQ requesters.
// Requester 0 has fixed priority; the rest rotate. A clear sequencer fills
// the array with FILL_VALUE after reset (optional) or on clear_start.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned       NUM_REQ        = 3,
  parameter int unsigned       ADDR_W         = 10,
  parameter int unsigned       DATA_W         = 8,
  parameter logic [DATA_W-1:0] FILL_VALUE     = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      clear_start,
  output logic                      busy,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_wren,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_data,
  input  logic [DATA_W-1:0]         mem_q
);

  localparam int unsigned       IDX_W     = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]  FIRST_RR  = IDX_W'(1);
  localparam logic [IDX_W-1:0]  LAST_RR   = IDX_W'(NUM_REQ - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                clr_last;   // last address has been issued; leave CLEAR next edge
  logic [NUM_REQ-1:0]  mask;       // previous winner, excluded for one arbitration
  logic [IDX_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0]  rd_pend;    // read granted last edge; data arrives next cycle

  logic [NUM_REQ-1:0]  eligible;
  logic [IDX_W-1:0]    rr_winner;
  logic                rr_valid;
  logic                grant_valid;
  logic [IDX_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [IDX_W-1:0]    next_ptr;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic                win_we;

  assign eligible = req & ~mask;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .eligible (eligible[NUM_REQ-1:1]),
    .ptr      (rr_ptr),
    .winner   (rr_winner),
    .valid    (rr_valid)
  );

  // Fixed priority for requester 0, otherwise the round-robin choice.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (eligible[0]) begin
      grant_valid = 1'b1;
    end else if (rr_valid) begin
      grant_valid = 1'b1;
      grant_idx   = rr_winner;
    end
  end

  assign grant_oh = NUM_REQ'(onehot_of(32'(grant_idx)));
  assign next_ptr = (rr_winner == LAST_RR) ? FIRST_RR : rr_winner + IDX_W'(1);
  assign win_addr = addr[32'(grant_idx)*ADDR_W +: ADDR_W];
  assign win_data = wdata[32'(grant_idx)*DATA_W +: DATA_W];
  assign win_we   = we[grant_idx];

  // Read data is the BRAM's registered output, qualified by rvalid.
  assign rdata = mem_q;

  // Mode FSM, clear sequencer, arbitration state and registered BRAM port.
  // NOTE: the BRAM contents are never reset here; the clear sequencer rewrites them instead.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= CLEAR_ON_RESET ? CLEAR : RUN;
      busy        <= CLEAR_ON_RESET;
      clr_cnt     <= '0;
      clr_last    <= 1'b0;
      mask        <= '0;
      rr_ptr      <= FIRST_RR;
      rd_pend     <= '0;
      ack         <= '0;
      rvalid      <= '0;
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere so later statements see pre-edge values.
      ack      <= '0;
      mem_wren <= 1'b0;
      rvalid   <= rd_pend;
      rd_pend  <= '0;
      unique case (state)
        CLEAR: begin
          mask <= '0;
          if (clr_last) begin
            state    <= RUN;
            busy     <= 1'b0;
            clr_last <= 1'b0;
          end else begin
            mem_wren    <= 1'b1;
            mem_address <= clr_cnt;
            mem_data    <= FILL_VALUE;
            clr_cnt     <= clr_cnt + ADDR_W'(1);
            clr_last    <= (clr_cnt == LAST_ADDR);
          end
        end
        RUN: begin
          if (clear_start) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
            mask    <= '0;
          end else if (grant_valid) begin
            ack         <= grant_oh;
            mask        <= grant_oh;
            mem_wren    <= win_we;
            mem_address <= win_addr;
            mem_data    <= win_data;
            rd_pend     <= win_we ? '0 : grant_oh;
            if (!eligible[0]) rr_ptr <= next_ptr;
          end else begin
            mask <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter with a 16-word BRAM model.
module tb_bram_port_arbiter;

  localparam int          NR   = 3;
  localparam int          AW   = 4;
  localparam int          DW   = 8;
  localparam logic [7:0]  FILL = 8'hA5;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           clear_start = 1'b0;
  logic           busy;
  logic [NR-1:0]  req = '0;
  logic [NR-1:0]  we = '0;
  logic [NR*AW-1:0] addr = '0;
  logic [NR*DW-1:0] wdata = '0;
  logic [NR-1:0]  ack;
  logic [NR-1:0]  rvalid;
  logic [DW-1:0]  rdata;
  logic           mem_wren;
  logic [AW-1:0]  mem_address;
  logic [DW-1:0]  mem_data;
  logic [DW-1:0]  mem_q;

  int n_checks = 0;
  int n_errors = 0;

  bram_port_arbiter #(
    .NUM_REQ        (NR),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .FILL_VALUE     (FILL),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear_start (clear_start),
    .busy        (busy),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .mem_wren    (mem_wren),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_q       (mem_q)
  );

  always #5 clock = ~clock;

  // Write-first synchronous BRAM with one-cycle read latency.
  logic [DW-1:0] bram [16];
  always @(posedge clock) begin
    if (mem_wren) begin
      bram[mem_address] <= mem_data;
      mem_q             <= mem_data;
    end else begin
      mem_q <= bram[mem_address];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input int i, input logic r, input logic w, input logic [3:0] a,
                         input logic [7:0] d);
    req[i]          = r;
    we[i]           = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  // Called right after reset release: expects 16 fill writes at 0..15, then busy low.
  task automatic clear_sweep(input string name);
    int k;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (!busy) break;
      check({name, " wr"}, {mem_wren, mem_address, mem_data}, {1'b1, 4'(k), FILL});
      k++;
    end
    check({name, " len"}, k, 16);
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] we;
    logic [2:0] exp_ack;
    logic [2:0] exp_rvalid;
  } vec_t;

  localparam int NT = 14;
  vec_t tbl [NT];

  // Reference model state for the random phase.
  int          last_win;
  int unsigned rr_q[$];
  logic [7:0]  shadow [16];
  logic [2:0]  pend_oh;
  logic [7:0]  pend_data;
  int          acked [3];

  task automatic new_cmd(input int i);
    set_cmd(i, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
  endtask

  initial begin
    int bad, cnt, win, found;
    logic [2:0] exp_ack;
    logic [3:0] a;

    // Stimulus table: all reads, reads return FILL since nothing was written yet.
    tbl[0]  = '{3'b111, 3'b000, 3'b001, 3'b000};
    tbl[1]  = '{3'b111, 3'b000, 3'b010, 3'b001};
    tbl[2]  = '{3'b111, 3'b000, 3'b001, 3'b010};
    tbl[3]  = '{3'b111, 3'b000, 3'b100, 3'b001};
    tbl[4]  = '{3'b111, 3'b000, 3'b001, 3'b100};
    tbl[5]  = '{3'b111, 3'b000, 3'b010, 3'b001};
    tbl[6]  = '{3'b111, 3'b000, 3'b001, 3'b010};
    tbl[7]  = '{3'b111, 3'b000, 3'b100, 3'b001};
    tbl[8]  = '{3'b110, 3'b000, 3'b010, 3'b100};
    tbl[9]  = '{3'b110, 3'b000, 3'b100, 3'b010};
    tbl[10] = '{3'b110, 3'b000, 3'b010, 3'b100};
    tbl[11] = '{3'b110, 3'b000, 3'b100, 3'b010};
    tbl[12] = '{3'b000, 3'b000, 3'b000, 3'b100};
    tbl[13] = '{3'b000, 3'b000, 3'b000, 3'b000};

    // Reset state and automatic clear.
    repeat (3) @(negedge clock);
    check("rst busy", busy, 1);
    check("rst outs", {ack, rvalid, mem_wren, mem_address, mem_data}, 0);
    reset_n = 1'b1;
    clear_sweep("clr0");

    // Requester 0 reads address 7 after the clear.
    set_cmd(0, 1'b1, 1'b0, 4'd7, 8'h00);
    @(negedge clock);
    check("rd7 ack", ack, 3'b001);
    @(negedge clock);
    check("rd7 rvalid", rvalid, 3'b001);
    check("rd7 rdata", rdata, FILL);
    set_cmd(0, 1'b0, 1'b0, 4'd0, 8'h00);
    @(negedge clock);

    // Table-driven arbitration sequence.
    addr = {4'd3, 4'd2, 4'd1};
    wdata = '0;
    for (int i = 0; i <= NT; i++) begin
      @(negedge clock);
      if (i > 0) begin
        check($sformatf("vec%0d ack", i - 1), ack, tbl[i-1].exp_ack);
        check($sformatf("vec%0d rvalid", i - 1), rvalid, tbl[i-1].exp_rvalid);
        if (tbl[i-1].exp_rvalid != 3'b000)
          check($sformatf("vec%0d rdata", i - 1), rdata, FILL);
      end
      if (i < NT) begin
        req = tbl[i].req;
        we  = tbl[i].we;
      end else begin
        req = '0;
        we  = '0;
      end
    end

    // Requester 1 writes 3C to address 5, then reads it back.
    set_cmd(1, 1'b1, 1'b1, 4'd5, 8'h3C);
    @(negedge clock);
    check("wr5 ack", ack, 3'b010);
    check("wr5 port", {mem_wren, mem_address, mem_data}, {1'b1, 4'd5, 8'h3C});
    @(negedge clock);
    check("wr5 masked", ack, 3'b000);
    check("wr5 no rvalid", rvalid, 3'b000);
    set_cmd(1, 1'b1, 1'b0, 4'd5, 8'h00);
    @(negedge clock);
    check("rd5 ack", ack, 3'b010);
    check("rd5 port", {mem_wren, mem_address}, {1'b0, 4'd5});
    @(negedge clock);
    check("rd5 rvalid", rvalid, 3'b010);
    check("rd5 rdata", rdata, 8'h3C);
    set_cmd(1, 1'b0, 1'b0, 4'd0, 8'h00);
    @(negedge clock);
    check("rd5 idle", ack, 3'b000);

    // clear_start coincides with a pending read from requester 2.
    set_cmd(2, 1'b1, 1'b0, 4'd3, 8'h00);
    clear_start = 1'b1;
    @(negedge clock);
    clear_start = 1'b0;
    check("clr1 start ack", ack, 3'b000);
    check("clr1 busy", busy, 1);
    bad = 0;
    cnt = 0;
    while (busy && cnt < 40) begin
      @(negedge clock);
      if (ack != 3'b000) bad++;
      cnt++;
    end
    check("clr1 no ack", bad, 0);
    check("clr1 len", cnt, 17);
    check("clr1 exit ack", ack, 3'b000);
    @(negedge clock);
    check("clr1 ack2", ack, 3'b100);
    @(negedge clock);
    check("clr1 rvalid2", rvalid, 3'b100);
    check("clr1 rdata2", rdata, FILL);
    set_cmd(2, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (2) @(negedge clock);

    // Random traffic against the behavioural model.
    last_win  = -1;
    rr_q      = {1, 2};
    pend_oh   = '0;
    pend_data = '0;
    foreach (shadow[i]) shadow[i] = FILL;
    foreach (acked[i]) acked[i] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clock);
      win = -1;
      if (req[0] && last_win != 0) begin
        win = 0;
      end else begin
        foreach (rr_q[k])
          if (win < 0 && req[rr_q[k]] && last_win != int'(rr_q[k])) win = int'(rr_q[k]);
      end
      if (win > 0)
        while (rr_q[$] != win) rr_q.push_back(rr_q.pop_front());
      exp_ack = (win >= 0) ? 3'(1 << win) : 3'b000;

      check($sformatf("rnd%0d ack", cyc), ack, exp_ack);
      check($sformatf("rnd%0d rvalid", cyc), rvalid, pend_oh);
      if (pend_oh != 3'b000) check($sformatf("rnd%0d rdata", cyc), rdata, pend_data);
      check($sformatf("rnd%0d wren", cyc), mem_wren, (win >= 0) && we[win]);
      if (win >= 0) begin
        a = addr[win*AW +: AW];
        check($sformatf("rnd%0d addr", cyc), mem_address, a);
        if (we[win]) begin
          check($sformatf("rnd%0d wdata", cyc), mem_data, wdata[win*DW +: DW]);
          shadow[a] = wdata[win*DW +: DW];
          pend_oh   = '0;
        end else begin
          pend_oh   = exp_ack;
          pend_data = shadow[a];
        end
      end else begin
        pend_oh = '0;
      end
      last_win = win;

      for (int i = 0; i < NR; i++) begin
        if (exp_ack[i]) begin
          acked[i] = 1;
        end else if (acked[i] != 0) begin
          acked[i] = 0;
          if ($urandom_range(0, 1) == 1) new_cmd(i);
          else req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          new_cmd(i);
        end
      end
    end
    req = '0;
    we  = '0;
    repeat (3) @(negedge clock);

    // Reset asserted in the middle of a clear, at address 9.
    clear_start = 1'b1;
    @(negedge clock);
    clear_start = 1'b0;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (mem_wren && busy && mem_address == 4'd9) begin
        found = 1;
        break;
      end
    end
    check("mid reached 9", found, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid rst busy", busy, 1);
    check("mid rst outs", {ack, rvalid, mem_wren, mem_address, mem_data}, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    clear_sweep("clr2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
